add_sub_reservation_station: RTL
================================

Name: add_sub_reservation_station

Overview:
Reservation station that sits in front of the add/sub execution unit. It buffers dispatched add/sub instructions and snoops the common data bus (CDB) for pending operands. It issues ready instructions to the unit over its valid/ready input handshake. Each entry's id (RS_OFFSET + index) is the renaming tag; the entry is held until its own result appears on the CDB, so tags stay unique while the result is in flight.

Parameters:
RS_ID_WIDTH, 5, width of every rs_id/tag.
RS_DEPTH, 4, number of entries (2..8).
RS_OFFSET, 0, rs_id of entry 0. RS_OFFSET+RS_DEPTH <= 2**RS_ID_WIDTH.

Ports:
clk  input  1  clock, rising edge
rst  input  1  synchronous reset, active-low (0 = reset)
in_valid  input  1  dispatch request
in_ready  output  1  a free entry exists
in_control  input  add_sub_decode_t  decoded operation
in_result_reg_addr  input  5  destination GPR
in_op1 / in_op2  input  32  operand value, used when its valid bit is set
in_op1_valid / in_op2_valid  input  1  operand value present
in_op1_tag / in_op2_tag  input  RS_ID_WIDTH  producer rs_id when not valid
in_ca / in_ca_valid / in_ca_tag  input  1/1/RS_ID_WIDTH  carry operand, same rules
cdb_valid  input  1  result broadcast
cdb_rs_id  input  RS_ID_WIDTH  producer id
cdb_result  input  32  result value
cdb_cr0_xer  input  cond_exception_t  producer flags; .CA supplies carry
out_valid  output  1  issue to unit (input_valid)
out_ready  input  1  unit input_ready
rs_id_out  output  RS_ID_WIDTH  issuing entry id
result_reg_addr_out  output  5
op1 / op2  output  32
carry_in  output  1
control  output  add_sub_decode_t

Behaviour:
- Entry state: busy, issued, control, dest, three operands (value, valid, tag).
- Reset (rst=0 at an edge): every busy/issued bit cleared; out_valid=0; rs_id_out, result_reg_addr_out, op1, op2, carry_in and control all 0. Reset mid-operation discards every entry and the output register.
- in_ready is derived combinationally from registered busy bits only: in_ready = some entry has busy=0.
- An entry freed by the CDB in a cycle does not raise in_ready until the next cycle.
- Dispatch: in_valid && in_ready at an edge writes the lowest-index free entry, with busy=1 and issued=0.
- Dispatch with same-cycle CDB: if a dispatched operand is not valid, cdb_valid is high, and cdb_rs_id equals its tag, the entry captures the CDB value and marks the operand valid. For carry, the captured value is cdb_cr0_xer.CA.
- Wakeup: at every edge, every busy entry's non-valid operand whose tag matches a valid CDB id captures the CDB value. All three operands may wake in the same cycle.
- Output register (single stage): loaded when out_valid=0 or out_ready=1.
  - It takes the lowest-index entry with busy=1, issued=0 and all operands valid, and sets that entry's issued=1.
  - If no entry qualifies, out_valid drops to 0 on that load.
  - While out_valid=1 and out_ready=0, all outputs hold stable.
- Latency:
  - Dispatch with all operands valid at edge E0 gives out_valid=1 after edge E0+1.
  - Operand woken at edge E gives issue after E+1.
  - With out_ready=1 held, one issue per cycle.
- Free: at an edge with cdb_valid=1 and cdb_rs_id == RS_OFFSET+i, entry i is cleared if it is busy and issued. CDB ids outside [RS_OFFSET, RS_OFFSET+RS_DEPTH) never free an entry.
- Wakeup and free by the same CDB event, in different entries, both occur.
- Never-valid operands: an operand left waiting on a tag that never broadcasts keeps its entry busy indefinitely; no timeout.

Test Plan:
- Reset with rst=0 for 2 cycles → out_valid=0 and in_ready=1. Dispatch op1=5, op2=7, all valid, RS_OFFSET=4 → out_valid after 2 edges, rs_id_out=4, op1=5, op2=7.
- Dispatch op1 waiting on tag 9. Two cycles later, CDB id 9 result 0x10 → op1=0x10 issued on the following edge.
- Dispatch waiting on tag 3 while CDB broadcasts id 3 with 0xFF in the same cycle → value captured, issue 2 edges later.
- Fill all 4 entries → in_ready=0. CDB with rs_id 5 (issued entry 1) → in_ready=1 next cycle; the next dispatch lands in entry 1.
- Entries 0 and 2 ready, out_ready=0 for 5 cycles → outputs hold entry 0 unchanged; entry 2 issues the cycle after out_ready rises.
- Carry: in_ca_valid=0, tag 2; CDB id 2 with CA=1 → carry_in=1 on issue.

Source files
------------

// File: rtl/add_sub_reservation_station_pkg.sv
// Shared payload types for the add/sub reservation station and its execution unit.
//   add_sub_decode_t  : decoded add/sub operation carried alongside the operands
//   cond_exception_t  : condition/exception flags a producer broadcasts on the CDB
package add_sub_reservation_station_pkg;

    typedef struct packed {
        logic subtract;
        logic use_carry;
        logic complement_op1;
        logic set_cr0;
        logic set_ca;
    } add_sub_decode_t;

    typedef struct packed {
        logic lt;
        logic gt;
        logic eq;
        logic so;
        logic ov;
        logic CA;
    } cond_exception_t;

endpackage

// File: rtl/add_sub_reservation_station_if.sv
// Bundles the dispatch, CDB snoop and issue signals of the add/sub reservation station.
//   slave  : the reservation station's view (takes dispatch and CDB, drives issue)
//   master : the surrounding pipeline's view (drives dispatch and CDB, takes issue)
interface add_sub_reservation_station_if #(
    parameter int unsigned RS_ID_WIDTH = 5
);
    // Dispatch
    logic                                            in_valid;
    logic                                            in_ready;
    add_sub_reservation_station_pkg::add_sub_decode_t in_control;
    logic [4:0]                                      in_result_reg_addr;
    logic [31:0]                                     in_op1;
    logic                                            in_op1_valid;
    logic [RS_ID_WIDTH-1:0]                          in_op1_tag;
    logic [31:0]                                     in_op2;
    logic                                            in_op2_valid;
    logic [RS_ID_WIDTH-1:0]                          in_op2_tag;
    logic                                            in_ca;
    logic                                            in_ca_valid;
    logic [RS_ID_WIDTH-1:0]                          in_ca_tag;
    // Common data bus
    logic                                            cdb_valid;
    logic [RS_ID_WIDTH-1:0]                          cdb_rs_id;
    logic [31:0]                                     cdb_result;
    add_sub_reservation_station_pkg::cond_exception_t cdb_cr0_xer;
    // Issue to the add/sub unit
    logic                                            out_valid;
    logic                                            out_ready;
    logic [RS_ID_WIDTH-1:0]                          rs_id_out;
    logic [4:0]                                      result_reg_addr_out;
    logic [31:0]                                     op1;
    logic [31:0]                                     op2;
    logic                                            carry_in;
    add_sub_reservation_station_pkg::add_sub_decode_t control;

    modport slave (
        input  in_valid, in_control, in_result_reg_addr,
               in_op1, in_op1_valid, in_op1_tag,
               in_op2, in_op2_valid, in_op2_tag,
               in_ca, in_ca_valid, in_ca_tag,
               cdb_valid, cdb_rs_id, cdb_result, cdb_cr0_xer,
               out_ready,
        output in_ready, out_valid, rs_id_out, result_reg_addr_out,
               op1, op2, carry_in, control
    );

    modport master (
        output in_valid, in_control, in_result_reg_addr,
               in_op1, in_op1_valid, in_op1_tag,
               in_op2, in_op2_valid, in_op2_tag,
               in_ca, in_ca_valid, in_ca_tag,
               cdb_valid, cdb_rs_id, cdb_result, cdb_cr0_xer,
               out_ready,
        input  in_ready, out_valid, rs_id_out, result_reg_addr_out,
               op1, op2, carry_in, control
    );

endinterface

// File: rtl/add_sub_reservation_station.sv
// Reservation station in front of the add/sub unit: buffers dispatched ops, snoops the
// CDB for missing operands, issues ready ops through a single output register, and
// frees an entry only when its own tag (RS_OFFSET + index) is broadcast on the CDB.
//   clk, rst : clock, synchronous active-low reset
//   bus      : dispatch (in_*), CDB snoop (cdb_*), issue (out_*, op1/op2, carry_in, ...)
module add_sub_reservation_station #(
    parameter int unsigned RS_ID_WIDTH = 5,
    parameter int unsigned RS_DEPTH    = 4,
    parameter int unsigned RS_OFFSET   = 0
) (
    input  logic                          clk,
    input  logic                          rst,
    add_sub_reservation_station_if.slave  bus
);
    import add_sub_reservation_station_pkg::*;

    localparam int unsigned IDX_W = (RS_DEPTH > 1) ? $clog2(RS_DEPTH) : 1;

    typedef struct packed {
        logic                   busy;
        logic                   issued;
        add_sub_decode_t        ctrl;
        logic [4:0]             dest;
        logic [31:0]            op1;
        logic                   op1_vld;
        logic [RS_ID_WIDTH-1:0] op1_tag;
        logic [31:0]            op2;
        logic                   op2_vld;
        logic [RS_ID_WIDTH-1:0] op2_tag;
        logic                   ca;
        logic                   ca_vld;
        logic [RS_ID_WIDTH-1:0] ca_tag;
    } entry_t;

    typedef struct packed {
        logic                   valid;
        logic [RS_ID_WIDTH-1:0] rs_id;
        logic [4:0]             dest;
        logic [31:0]            op1;
        logic [31:0]            op2;
        logic                   carry;
        add_sub_decode_t        ctrl;
    } issue_t;

    entry_t                 ent_q [RS_DEPTH];
    entry_t                 ent_d [RS_DEPTH];
    entry_t                 new_ent;
    issue_t                 out_q;
    issue_t                 out_d;
    logic                   free_found;
    logic [IDX_W-1:0]       free_idx;
    logic                   iss_found;
    logic [IDX_W-1:0]       iss_idx;
    logic                   load;
    logic                   unused_cr0;

    // A waiting operand wakes when a valid CDB broadcast carries its tag.
    function automatic logic wake(input logic vld, input logic [RS_ID_WIDTH-1:0] tag,
                                  input logic cdb_v, input logic [RS_ID_WIDTH-1:0] cdb_id);
        return !vld && cdb_v && (tag == cdb_id);
    endfunction

    // Only the CA flag is consumed from the producer's flags.
    assign unused_cr0 = ^bus.cdb_cr0_xer;

    // Lowest free entry and lowest issuable entry, both from registered state only.
    always_comb begin
        free_found = 1'b0;
        free_idx   = '0;
        iss_found  = 1'b0;
        iss_idx    = '0;
        for (int i = 0; i < RS_DEPTH; i++) begin
            if (!ent_q[i].busy && !free_found) begin
                free_found = 1'b1;
                free_idx   = IDX_W'(i);
            end
            if (ent_q[i].busy && !ent_q[i].issued && ent_q[i].op1_vld &&
                ent_q[i].op2_vld && ent_q[i].ca_vld && !iss_found) begin
                iss_found = 1'b1;
                iss_idx   = IDX_W'(i);
            end
        end
    end

    // Incoming entry, with same-cycle CDB capture for operands dispatched as waiting.
    always_comb begin
        logic w1, w2, wc;
        w1 = wake(bus.in_op1_valid, bus.in_op1_tag, bus.cdb_valid, bus.cdb_rs_id);
        w2 = wake(bus.in_op2_valid, bus.in_op2_tag, bus.cdb_valid, bus.cdb_rs_id);
        wc = wake(bus.in_ca_valid,  bus.in_ca_tag,  bus.cdb_valid, bus.cdb_rs_id);
        new_ent         = '0;
        new_ent.busy    = 1'b1;
        new_ent.ctrl    = bus.in_control;
        new_ent.dest    = bus.in_result_reg_addr;
        new_ent.op1     = w1 ? bus.cdb_result : bus.in_op1;
        new_ent.op1_vld = bus.in_op1_valid || w1;
        new_ent.op1_tag = bus.in_op1_tag;
        new_ent.op2     = w2 ? bus.cdb_result : bus.in_op2;
        new_ent.op2_vld = bus.in_op2_valid || w2;
        new_ent.op2_tag = bus.in_op2_tag;
        new_ent.ca      = wc ? bus.cdb_cr0_xer.CA : bus.in_ca;
        new_ent.ca_vld  = bus.in_ca_valid || wc;
        new_ent.ca_tag  = bus.in_ca_tag;
    end

    // Per-entry wakeup, free, issue marking and dispatch; output register load.
    always_comb begin
        ent_d = ent_q;
        out_d = out_q;
        load  = !out_q.valid || bus.out_ready;
        if (load) begin
            out_d.valid = iss_found;
        end
        for (int i = 0; i < RS_DEPTH; i++) begin
            if (ent_q[i].busy) begin
                if (wake(ent_q[i].op1_vld, ent_q[i].op1_tag, bus.cdb_valid, bus.cdb_rs_id)) begin
                    ent_d[i].op1     = bus.cdb_result;
                    ent_d[i].op1_vld = 1'b1;
                end
                if (wake(ent_q[i].op2_vld, ent_q[i].op2_tag, bus.cdb_valid, bus.cdb_rs_id)) begin
                    ent_d[i].op2     = bus.cdb_result;
                    ent_d[i].op2_vld = 1'b1;
                end
                if (wake(ent_q[i].ca_vld, ent_q[i].ca_tag, bus.cdb_valid, bus.cdb_rs_id)) begin
                    ent_d[i].ca     = bus.cdb_cr0_xer.CA;
                    ent_d[i].ca_vld = 1'b1;
                end
            end
            // The entry's own result on the CDB retires it; its tag becomes reusable.
            if (bus.cdb_valid && (bus.cdb_rs_id == RS_ID_WIDTH'(RS_OFFSET + i)) &&
                ent_q[i].busy && ent_q[i].issued) begin
                ent_d[i].busy   = 1'b0;
                ent_d[i].issued = 1'b0;
            end
            if (load && iss_found && (iss_idx == IDX_W'(i))) begin
                ent_d[i].issued = 1'b1;
                out_d.rs_id     = RS_ID_WIDTH'(RS_OFFSET + i);
                out_d.dest      = ent_q[i].dest;
                out_d.op1       = ent_q[i].op1;
                out_d.op2       = ent_q[i].op2;
                out_d.carry     = ent_q[i].ca;
                out_d.ctrl      = ent_q[i].ctrl;
            end
            if (bus.in_valid && free_found && (free_idx == IDX_W'(i))) begin
                ent_d[i] = new_ent;
            end
        end
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < RS_DEPTH; i++) begin
                ent_q[i] <= '0;
            end
            out_q <= '0;
        end else begin
            for (int i = 0; i < RS_DEPTH; i++) begin
                ent_q[i] <= ent_d[i];
            end
            out_q <= out_d;
        end
    end

    assign bus.in_ready            = free_found;
    assign bus.out_valid           = out_q.valid;
    assign bus.rs_id_out           = out_q.rs_id;
    assign bus.result_reg_addr_out = out_q.dest;
    assign bus.op1                 = out_q.op1;
    assign bus.op2                 = out_q.op2;
    assign bus.carry_in            = out_q.carry;
    assign bus.control             = out_q.ctrl;

endmodule
